// File: rtl/dwc_pkg.sv
// Shared types and helpers for the data-width converters (wide-to-narrow unpacker,
// narrow-to-wide packer).
package dwc_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      DRAIN = 1'b1
   } dwc_unpack_state_e;

   // Word index width; a ratio of 1 still needs a 1-bit index to keep ports legal.
   function automatic int dwc_cw(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/dwc_rsp_unpack.sv
// Wide-to-narrow response unpacker: one IN_W beat in, up to RATIO OUT_W words out, 1 cycle
// latency, 1 word/cycle; a held word stalls intake, next beat loads on the last-word edge.
module dwc_rsp_unpack
   import dwc_pkg::*;
#(
   parameter int IN_W      = 128,
   parameter int OUT_W     = 32,
   parameter int RATIO     = IN_W / OUT_W,
   parameter bit MSW_FIRST = 1'b0,
   parameter int CW        = dwc_cw(RATIO)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [CW:0]      in_nwords,
   input  logic             in_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic             out_err
);

   localparam int          LW       = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CW:0] RATIO_NW = (CW+1)'(RATIO);
   localparam logic [CW:0] ONE_NW   = (CW+1)'(1);

   if ((OUT_W <= 0) || (IN_W % OUT_W != 0)) begin : g_bad_width
      $error("dwc_rsp_unpack: IN_W must be a positive integer multiple of OUT_W");
   end

   dwc_unpack_state_e state_q, state_d;
   logic [CW:0]       idx_q, idx_d;
   logic [IN_W-1:0]   buf_data_q, buf_data_d;
   logic              buf_err_q, buf_err_d;
   logic [CW:0]       buf_nw_q, buf_nw_d;
   logic              rdy_en_q;

   logic [CW:0]       nw_cap;
   logic [CW:0]       word_pos;
   logic [LW-1:0]     word_lsb;
   logic              drain;
   logic              last_word;
   logic              xfer;
   logic              accept;

   // in_ready stays low until the first edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         idx_q      <= '0;
         buf_data_q <= '0;
         buf_err_q  <= 1'b0;
         buf_nw_q   <= '0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         buf_data_q <= buf_data_d;
         buf_err_q  <= buf_err_d;
         buf_nw_q   <= buf_nw_d;
         rdy_en_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      buf_data_d = buf_data_q;
      buf_err_d  = buf_err_q;
      buf_nw_d   = buf_nw_q;

      // Zero means a full beat; oversize counts are clamped rather than trusted.
      nw_cap = in_nwords;
      if ((in_nwords == '0) || (in_nwords > RATIO_NW)) begin
         nw_cap = RATIO_NW;
      end

      drain     = (state_q == DRAIN);
      word_pos  = MSW_FIRST ? (RATIO_NW - ONE_NW - idx_q) : idx_q;
      word_lsb  = LW'(int'(word_pos) * OUT_W);
      last_word = (idx_q == (buf_nw_q - ONE_NW));

      out_valid = drain;
      out_data  = drain ? buf_data_q[word_lsb +: OUT_W] : '0;
      out_last  = drain && last_word;
      out_err   = drain && buf_err_q;

      xfer     = out_valid && out_ready;
      in_ready = rdy_en_q && !flush && ((state_q == EMPTY) || (xfer && out_last));
      accept   = in_valid && in_ready;

      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer) begin
               if (!last_word) begin
                  idx_d = idx_q + ONE_NW;
               end else if (!accept) begin
                  state_d = EMPTY;
                  idx_d   = '0;
               end
            end
         end
         default: state_d = EMPTY;
      endcase

      if (accept) begin
         buf_data_d = in_data;
         buf_err_d  = in_err;
         buf_nw_d   = nw_cap;
         idx_d      = '0;
      end

      // Flush discards the buffered beat even if its word was taken this cycle.
      if (flush) begin
         state_d = EMPTY;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         assert (in_nwords <= RATIO_NW)
            else $error("dwc_rsp_unpack: in_nwords %0d exceeds RATIO %0d", in_nwords, RATIO);
      end
   end

endmodule

// File: tb/tb_dwc_rsp_unpack.sv
// Directed bench: 128->32 unpacker in both word orders plus a 32->32 register-slice build.
module tb_dwc_rsp_unpack;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] BEAT_X = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
   localparam logic [127:0] BEAT_Y = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
   localparam logic [127:0] BEAT_Z = 128'h0000_0004_0000_0003_0000_0002_0000_0001;

   logic [31:0] x_w [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
   logic [31:0] y_w [4] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
   logic [31:0] z_w [4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
   logic        bp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   int          bp_k   [7] = '{0, 1, 1, 1, 2, 2, 3};
   logic [31:0] c_d    [4] = '{32'hCAFE_0001, 32'hCAFE_0002, 32'h0BAD_0003, 32'h1234_5678};

   // a_*: 128->32 LSW first; b_*: 128->32 MSW first; c_*: 32->32.
   logic         a_flush, a_in_valid, a_in_ready, a_in_err, a_out_valid, a_out_ready;
   logic         a_out_last, a_out_err;
   logic [127:0] a_in_data;
   logic [2:0]   a_in_nwords;
   logic [31:0]  a_out_data;

   logic         b_flush, b_in_valid, b_in_ready, b_in_err, b_out_valid, b_out_ready;
   logic         b_out_last, b_out_err;
   logic [127:0] b_in_data;
   logic [2:0]   b_in_nwords;
   logic [31:0]  b_out_data;

   logic         c_flush, c_in_valid, c_in_ready, c_in_err, c_out_valid, c_out_ready;
   logic         c_out_last, c_out_err;
   logic [31:0]  c_in_data;
   logic [1:0]   c_in_nwords;
   logic [31:0]  c_out_data;

   dwc_rsp_unpack #(.IN_W(128), .OUT_W(32), .MSW_FIRST(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_nwords(a_in_nwords), .in_err(a_in_err),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_last(a_out_last), .out_err(a_out_err)
   );

   dwc_rsp_unpack #(.IN_W(128), .OUT_W(32), .MSW_FIRST(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_nwords(b_in_nwords), .in_err(b_in_err),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .out_err(b_out_err)
   );

   dwc_rsp_unpack #(.IN_W(32), .OUT_W(32), .MSW_FIRST(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(c_flush),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .in_nwords(c_in_nwords), .in_err(c_in_err),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .out_last(c_out_last), .out_err(c_out_err)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_nwords = '0; a_in_err = 1'b0;
      a_out_ready = 1'b0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_nwords = '0; b_in_err = 1'b0;
      b_out_ready = 1'b0;
      c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_in_nwords = '0; c_in_err = 1'b0;
      c_out_ready = 1'b0;

      #12;
      check("rst in_ready", a_in_ready, 1'b0);
      check("rst out_valid", a_out_valid, 1'b0);
      check("rst out_data", a_out_data, 32'h0);
      check("rst out_last", a_out_last, 1'b0);
      check("rst out_err", a_out_err, 1'b0);
      check("rst c in_ready", c_in_ready, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      #1;
      check("post-rst in_ready", a_in_ready, 1'b1);
      check("post-rst out_valid", a_out_valid, 1'b0);

      // Full beat, LSW first.
      a_in_valid = 1'b1; a_in_data = BEAT_X; a_in_nwords = 3'd0; a_out_ready = 1'b1;
      #1;
      check("full accept", a_in_ready, 1'b1);
      next_cycle();
      a_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("full valid", a_out_valid, 1'b1);
         check("full data", a_out_data, x_w[k]);
         check("full last", a_out_last, k == 3);
         check("full in_ready", a_in_ready, k == 3);
         next_cycle();
      end
      #1;
      check("full empty", a_out_valid, 1'b0);

      // Two beats back to back with in_valid held high.
      a_in_valid = 1'b1; a_in_data = BEAT_X;
      #1;
      check("b2b accept", a_in_ready, 1'b1);
      next_cycle();
      a_in_data = BEAT_Y;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("b2b valid", a_out_valid, 1'b1);
         check("b2b data", a_out_data, (k < 4) ? x_w[k] : y_w[k-4]);
         check("b2b last", a_out_last, (k % 4) == 3);
         check("b2b in_ready", a_in_ready, (k % 4) == 3);
         next_cycle();
         if (k == 3) a_in_valid = 1'b0;
      end
      #1;
      check("b2b empty", a_out_valid, 1'b0);

      // Backpressure with error flag carried on every word.
      a_in_valid = 1'b1; a_in_data = BEAT_Z; a_in_err = 1'b1; a_out_ready = 1'b0;
      #1;
      check("bp accept", a_in_ready, 1'b1);
      next_cycle();
      a_in_valid = 1'b0; a_in_err = 1'b0;
      for (int k = 0; k < 7; k++) begin
         a_out_ready = bp_rdy[k];
         #1;
         check("bp valid", a_out_valid, 1'b1);
         check("bp data", a_out_data, z_w[bp_k[k]]);
         check("bp last", a_out_last, bp_k[k] == 3);
         check("bp err", a_out_err, 1'b1);
         next_cycle();
      end
      #1;
      check("bp empty", a_out_valid, 1'b0);
      a_out_ready = 1'b1;

      // Partial beat of 3 words, LSW first.
      a_in_valid = 1'b1; a_in_data = BEAT_Y; a_in_nwords = 3'd3;
      #1;
      next_cycle();
      a_in_valid = 1'b0; a_in_nwords = 3'd0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("part data", a_out_data, y_w[k]);
         check("part last", a_out_last, k == 2);
         check("part err", a_out_err, 1'b0);
         next_cycle();
      end
      #1;
      check("part empty", a_out_valid, 1'b0);

      // Flush at idx 1 with a new beat offered in the same cycle.
      a_in_valid = 1'b1; a_in_data = BEAT_X;
      #1;
      next_cycle();
      a_in_valid = 1'b0;
      #1;
      check("flush w0", a_out_data, x_w[0]);
      next_cycle();
      a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = BEAT_Y;
      #1;
      check("flush in_ready", a_in_ready, 1'b0);
      check("flush w1", a_out_data, x_w[1]);
      next_cycle();
      a_flush = 1'b0;
      #1;
      check("flush out_valid", a_out_valid, 1'b0);
      check("flush reopen", a_in_ready, 1'b1);
      next_cycle();
      a_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("after flush data", a_out_data, y_w[k]);
         check("after flush last", a_out_last, k == 3);
         next_cycle();
      end
      #1;
      check("after flush empty", a_out_valid, 1'b0);

      // MSW first, two valid words: words 3 then 2.
      b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = BEAT_X; b_in_nwords = 3'd2;
      #1;
      check("msw accept", b_in_ready, 1'b1);
      next_cycle();
      b_in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("msw valid", b_out_valid, 1'b1);
         check("msw data", b_out_data, (k == 0) ? x_w[3] : x_w[2]);
         check("msw last", b_out_last, k == 1);
         next_cycle();
      end
      #1;
      check("msw empty", b_out_valid, 1'b0);
      check("msw in_ready", b_in_ready, 1'b1);

      // Single-word build streams as a register slice with error forwarded.
      c_out_ready = 1'b1; c_in_err = 1'b1; c_in_nwords = 2'd0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            c_in_valid = 1'b1; c_in_data = c_d[k];
         end else begin
            c_in_valid = 1'b0;
         end
         #1;
         if (k < 4) check("r1 in_ready", c_in_ready, 1'b1);
         if (k > 0) begin
            check("r1 valid", c_out_valid, 1'b1);
            check("r1 data", c_out_data, c_d[k-1]);
            check("r1 last", c_out_last, 1'b1);
            check("r1 err", c_out_err, 1'b1);
         end else begin
            check("r1 idle", c_out_valid, 1'b0);
         end
         next_cycle();
      end
      #1;
      check("r1 empty", c_out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dwc_rsp_unpack.md
# dwc_rsp_unpack

Parametrised wide-to-narrow response unpacker between the co-processor response FIFO and the processor response port. It accepts one IN_W-bit beat per valid/ready handshake and emits its OUT_W-bit words with a programmable word order and a per-beat valid-word count. Output throughput is one word per cycle with zero-bubble back-to-back beats. A last-word marker and an error flag are forwarded with each word.

## Interface
- IN_W, 128: input beat width; must be an integer multiple of OUT_W.
- OUT_W, 32: output word width.
- RATIO, IN_W/OUT_W: words per beat; 1 is legal and makes the block a one-entry register slice.
- MSW_FIRST, 0: 0 sends word 0 (bits OUT_W-1:0) first; 1 sends the most-significant word first.
- CW, (RATIO>1 ? $clog2(RATIO) : 1): word index width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous drop of the buffered beat.
- in_valid  in  1  beat offered by the FIFO.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  IN_W  beat payload.
- in_nwords  in  CW+1  number of valid words, 1..RATIO; 0 means RATIO.
- in_err  in  1  error status of the beat.
- out_valid  out  1  word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_W  current word.
- out_last  out  1  current word is the final valid word of the beat.
- out_err  out  1  copy of in_err for every word of the beat.

## Operation
- Registered state:
  - buf_data, buf_err
  - buf_nw (nwords; 0 is normalised to RATIO at capture)
  - idx (CW+1 bits)
  - state enum {EMPTY, DRAIN}
- EMPTY:
  - in_ready=1.
  - On accept: capture the beat, idx=0, go to DRAIN.
- DRAIN:
  - out_valid=1.
  - out_data = buf_data word at position p: p=idx when MSW_FIRST=0; p=RATIO-1-idx when MSW_FIRST=1.
  - out_last = (idx == buf_nw-1).
  - Handshake with out_last=0: idx+1.
  - Handshake with out_last=1:
    - if in_valid, capture the new beat, idx=0, stay in DRAIN;
    - otherwise go to EMPTY.
- in_ready = (state==EMPTY) || (out_valid && out_ready && out_last), gated low while flush=1. This is a combinational path from out_ready to in_ready; it is intended.
- Partial beats send only buf_nw words. The unused words are never emitted.
- flush=1: state goes to EMPTY next cycle, idx=0, the buffered beat is discarded, and no input is accepted that cycle. flush overrides a simultaneous in_valid or out_ready; the output handshake in that cycle still counts as a transfer.
- in_nwords > RATIO is illegal. The RTL clamps it to RATIO, and an assertion flags it.

## Timing
- Reset values:
  - in_ready=0 during reset, then 1 in EMPTY.
  - out_valid=0, out_data=0, out_last=0, out_err=0.
  - state=EMPTY, idx=0, buf_*=0.
- Latency: a beat accepted at edge N gives word 0 valid in the cycle after edge N (1 cycle).
- Throughput: 1 word/cycle while out_ready=1. A full beat drains in RATIO cycles. The next beat is captured on the last-word edge, with no idle cycle.
- out_data, out_last and out_err are held stable while out_valid && !out_ready.
- out_valid never drops without a handshake, except on flush or reset.
- RATIO=1: every word is last. The block behaves as a pipeline register with full throughput.
- Reset asserted mid-beat: all state clears asynchronously. The remaining words are lost and no partial output follows.

## Structure
- Package dwc_pkg:
  - state typedef dwc_unpack_state_e {EMPTY, DRAIN};
  - function dwc_cw(ratio) for the index width, shared with the narrow-to-wide packer.
- Single module. The word select is an indexed part-select, and no sub-module is warranted.
- Elaboration-time assertions: IN_W % OUT_W == 0 and OUT_W > 0.

## Test plan
- Full beat, IN_W=128, OUT_W=32, MSW_FIRST=0, data 0x44443333_22221111_... with out_ready=1 -> words 0x....1111.., then 0x2222.., 0x3333.., 0x4444.. on 4 consecutive cycles; out_last only on the 4th; in_ready=1 in the 4th cycle.
- Two beats back to back with in_valid held high -> 8 consecutive out_valid cycles with no bubble; the second beat is accepted on the edge of the first beat's last word.
- MSW_FIRST=1, in_nwords=2 -> only words 3 and 2 are sent; out_last is set on word 2; then EMPTY.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_data is held during stalls; no word is lost or duplicated; idx only advances on handshake.
- flush asserted while idx=1 of a 4-word beat, with in_valid=1 in the same cycle -> out_valid=0 next cycle; the new beat is not accepted that cycle; the next beat then unpacks from word 0.
- RATIO=1 (IN_W=OUT_W=32) with in_err=1 -> the same data appears one cycle later with out_last=1 and out_err=1; streaming runs at 1 word/cycle.
